// File: rtl/wt_mul8_seq.sv
// Unsigned 8x8 multiplier that steps one shared 4x4 Wallace-tree core through four
// nibble partial products and accumulates them into a 16-bit product.
module wt_mul8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        busy,
  output logic        done,
  output logic [15:0] Product,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_step;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [15:0] r_acc;
  logic [15:0] r_product;

  logic [3:0]  w_nib_a;
  logic [3:0]  w_nib_b;
  logic [7:0]  w_pp;
  logic [3:0]  w_shift;
  logic [15:0] w_pp_shifted;
  logic [15:0] w_sum;

  // step[0] picks the high nibble of A, step[1] the high nibble of B.
  assign w_nib_a = r_step[0] ? r_a[7:4] : r_a[3:0];
  assign w_nib_b = r_step[1] ? r_b[7:4] : r_b[3:0];

  WT_Multiplier4x4 u_core (
    .A (w_nib_a),
    .B (w_nib_b),
    .P (w_pp)
  );

  assign w_shift      = {r_step[1] & r_step[0], r_step[1] ^ r_step[0], 2'b00};
  assign w_pp_shifted = {8'h00, w_pp} << w_shift;
  assign w_sum        = r_acc + w_pp_shifted;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: if (start) w_next_state = MUL;
      MUL: begin
        busy = 1'b1;
        if (r_step == 2'd3) w_next_state = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Product is only written on the final step, so it holds between completions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step    <= 2'd0;
      r_a       <= 8'h00;
      r_b       <= 8'h00;
      r_acc     <= 16'h0000;
      r_product <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a    <= A;
            r_b    <= B;
            r_acc  <= 16'h0000;
            r_step <= 2'd0;
          end
        end
        MUL: begin
          r_acc  <= w_sum;
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) r_product <= w_sum;
        end
        default: ;
      endcase
    end
  end

  assign Product   = r_product;
  assign dbg_state = r_state;

endmodule

// Combinational 4x4 unsigned Wallace-tree multiplier: one carry-save layer
// reduces the partial-product matrix, a final adder resolves the rows.
module WT_Multiplier4x4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P
);

  logic [3:0] w_p0, w_p1, w_p2, w_p3;
  logic       w_s1, w_c1, w_s2, w_c2, w_s3, w_c3, w_s4, w_c4, w_s5, w_c5;
  logic [7:0] w_row0, w_row1, w_row2;

  assign w_p0 = A & {4{B[0]}};
  assign w_p1 = A & {4{B[1]}};
  assign w_p2 = A & {4{B[2]}};
  assign w_p3 = A & {4{B[3]}};

  assign {w_c1, w_s1} = {1'b0, w_p0[1]} + {1'b0, w_p1[0]};
  assign {w_c2, w_s2} = {1'b0, w_p0[2]} + {1'b0, w_p1[1]} + {1'b0, w_p2[0]};
  assign {w_c3, w_s3} = {1'b0, w_p0[3]} + {1'b0, w_p1[2]} + {1'b0, w_p2[1]};
  assign {w_c4, w_s4} = {1'b0, w_p1[3]} + {1'b0, w_p2[2]} + {1'b0, w_p3[1]};
  assign {w_c5, w_s5} = {1'b0, w_p2[3]} + {1'b0, w_p3[2]};

  assign w_row0 = {1'b0, w_p3[3], w_s5, w_s4, w_s3, w_s2, w_s1, w_p0[0]};
  assign w_row1 = {1'b0, w_c5, w_c4, w_c3, w_c2, w_c1, 2'b00};
  assign w_row2 = {4'h0, w_p3[0], 3'b000};

  assign P = w_row0 + w_row1 + w_row2;

endmodule

// File: tb/tb_wt_mul8_seq.sv
// Directed bench for wt_mul8_seq: vector table of products with cycle-exact
// handshake checks, plus sequences for ignored start, mid-run reset and held start.
module tb_wt_mul8_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        busy;
  logic        done;
  logic [15:0] Product;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[8];

  wt_mul8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .Product   (Product),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    A     = 8'h00;
    B     = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Launch one operation and check every cycle of it; called on a negedge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p,
                        input logic [15:0] prev);
    logic [15:0] exp_p;
    exp_q.push_back(p);
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("busy_c%0d", k), {31'b0, busy}, 32'd1);
      chk($sformatf("done_c%0d", k), {31'b0, done}, 32'd0);
      chk($sformatf("hold_c%0d", k), {16'b0, Product}, {16'b0, prev});
      @(negedge clk);
    end
    exp_p = exp_q.pop_front();
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("busy_at_done", {31'b0, busy}, 32'd0);
    chk($sformatf("product_%02h_%02h", a, b), {16'b0, Product}, {16'b0, exp_p});
    @(negedge clk);
    chk("done_drop", {31'b0, done}, 32'd0);
    chk("product_hold", {16'b0, Product}, {16'b0, exp_p});
  endtask

  initial begin
    logic [15:0] prev;
    int          n_done;
    int          last_done;
    int          bad_gap;
    int          bad_prod;
    int          overlap;

    vecs[0] = '{a: 8'hFF, b: 8'hFF, p: 16'hFE01};
    vecs[1] = '{a: 8'h12, b: 8'h34, p: 16'h03A8};
    vecs[2] = '{a: 8'hC8, b: 8'h03, p: 16'h0258};
    vecs[3] = '{a: 8'h00, b: 8'hAB, p: 16'h0000};
    vecs[4] = '{a: 8'h01, b: 8'hFF, p: 16'h00FF};
    vecs[5] = '{a: 8'hA5, b: 8'h5A, p: 16'h3A02};
    vecs[6] = '{a: 8'hF0, b: 8'h0F, p: 16'h0E10};
    vecs[7] = '{a: 8'h80, b: 8'h02, p: 16'h0100};

    do_reset();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_product", {16'b0, Product}, 32'h0);
    chk("rst_state", {30'b0, dbg_state}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_quiet", {30'b0, busy, done}, 32'd0);
    end

    // vector table
    prev = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, prev);
      prev = vecs[i].p;
      @(negedge clk);
    end

    // operands change and start pulses mid-run: ignored
    A = 8'h0F; B = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 8'hFF; B = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("ign_busy_c4", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("ign_done", {31'b0, done}, 32'd1);
    chk("ign_product", {16'b0, Product}, 32'h00F0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("ign_no_relaunch", {30'b0, busy, done}, 32'd0);
    end

    // reset during step2, start asserted alongside it
    A = 8'hFF; B = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_done", {31'b0, done}, 32'd0);
    chk("mrst_product", {16'b0, Product}, 32'h0);
    chk("mrst_state", {30'b0, dbg_state}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mrst_no_done", {30'b0, busy, done}, 32'd0);
    end
    run_op(8'h10, 8'h10, 16'h0100, 16'h0000);
    @(negedge clk);

    // start held high for 20 cycles
    A = 8'h0F; B = 8'h0F; start = 1'b1;
    n_done = 0; last_done = -1; bad_gap = 0; bad_prod = 0; overlap = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (busy && done) overlap++;
      if (done) begin
        if (Product !== 16'h00E1) bad_prod++;
        if (last_done >= 0 && (c - last_done) != 6) bad_gap++;
        if (last_done < 0 && c != 5) bad_gap++;
        last_done = c;
        n_done++;
      end
    end
    start = 1'b0;
    chk("held_done_count", n_done, 32'd3);
    chk("held_done_spacing", bad_gap, 32'd0);
    chk("held_product", bad_prod, 32'd0);
    chk("held_busy_done_overlap", overlap, 32'd0);
    chk("held_last_product", {16'b0, Product}, 32'h00E1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
